cnt_bcd_conv: RTL and testbench

- Downstream stage of the 10-bit free-running counter (ex_cnt); consumes its cnt bus directly.
- Converts the binary count into packed BCD digits using sequential shift-add-3 (double-dabble), one bit per clock.
- Produces a registered BCD word and a one-cycle valid pulse for the seven-segment scan driver that follows.
- A conversion starts only when the input value differs from the last converted value, so the block is self-triggering and needs no handshake from the counter.

---
 rtl/cnt_bcd_conv_pkg.sv | 14 +
 rtl/cnt_bcd_conv_bcd_add3.sv | 13 +
 rtl/cnt_bcd_conv.sv | 102 ++++++++++
 tb/tb_cnt_bcd_conv.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cnt_bcd_conv_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD display stage.
package cnt_bcd_conv_pkg;

  localparam int unsigned DigitW    = 4;
  localparam int unsigned DefDw     = 10;
  localparam int unsigned DefDigits = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/cnt_bcd_conv_bcd_add3.sv
// Double-dabble digit correction: digits of 5 or more get +3 before the shift.
module cnt_bcd_conv_bcd_add3
  import cnt_bcd_conv_pkg::*;
(
  input  logic [DigitW-1:0] digit_i,
  output logic [DigitW-1:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= DigitW'(5)) ? digit_i + DigitW'(3) : digit_i;
  end

endmodule

// File: rtl/cnt_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) that
// self-triggers whenever the counter value differs from the last converted one.
module cnt_bcd_conv
  import cnt_bcd_conv_pkg::*;
#(
  parameter int unsigned DW     = DefDw,
  parameter int unsigned DIGITS = DefDigits
) (
  input  logic                     sclk,
  input  logic                     rst_n,
  input  logic [DW-1:0]            cnt,
  output logic [DigitW*DIGITS-1:0] bcd,
  output logic                     bcd_vld,
  output logic                     busy
);

  localparam int unsigned BcdW = DigitW * DIGITS;
  localparam int unsigned CntW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DW - 1);

  state_e            state_q, state_d;
  logic [DW-1:0]     src_q, src_d;
  logic [DW-1:0]     last_q, last_d;
  logic [BcdW-1:0]   scratch_q, scratch_d;
  logic [BcdW-1:0]   corr;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              first_q, first_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              vld_q, vld_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    cnt_bcd_conv_bcd_add3 u_add3 (
      .digit_i (scratch_q[g*DigitW +: DigitW]),
      .digit_o (corr[g*DigitW +: DigitW])
    );
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    last_d    = last_q;
    scratch_d = scratch_q;
    bit_cnt_d = bit_cnt_q;
    first_d   = first_q;
    bcd_d     = bcd_q;
    vld_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (first_q || (cnt != last_q)) begin
          src_d     = cnt;
          last_d    = cnt;
          scratch_d = '0;
          bit_cnt_d = '0;
          first_d   = 1'b0;
          state_d   = StShift;
        end
      end
      StShift: begin
        // Corrected digits shift up; the top corrected bit can never be set.
        scratch_d = BcdW'({corr, src_q[DW-1]});
        src_d     = src_q << 1;
        bit_cnt_d = bit_cnt_q + CntW'(1);
        if (bit_cnt_q == LastBit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d   = scratch_q;
        vld_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      src_q     <= '0;
      last_q    <= '0;
      scratch_q <= '0;
      bit_cnt_q <= '0;
      first_q   <= 1'b1;
      bcd_q     <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      last_q    <= last_d;
      scratch_q <= scratch_d;
      bit_cnt_q <= bit_cnt_d;
      first_q   <= first_d;
      bcd_q     <= bcd_d;
      vld_q     <= vld_d;
    end
  end

  assign bcd     = bcd_q;
  assign bcd_vld = vld_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_cnt_bcd_conv.sv
// Directed self-checking bench for cnt_bcd_conv at DW=10, DIGITS=4.
module tb_cnt_bcd_conv;

  logic        sclk;
  logic        rst_n;
  logic [9:0]  cnt;
  logic [15:0] bcd;
  logic        bcd_vld;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  cnt_bcd_conv dut (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .cnt     (cnt),
    .bcd     (bcd),
    .bcd_vld (bcd_vld),
    .busy    (busy)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Watches n falling edges; positions are counted from the edge after the stimulus.
  task automatic observe(input int n, output int first_pos, output int pulses,
                         output int busy_cyc, output logic [15:0] first_bcd);
    first_pos = 0;
    pulses    = 0;
    busy_cyc  = 0;
    first_bcd = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge sclk);
      if (busy) busy_cyc++;
      if (bcd_vld) begin
        pulses++;
        if (first_pos == 0) begin
          first_pos = k;
          first_bcd = bcd;
        end
      end
    end
  endtask

  task automatic test_reset;
    int pos, pulses, bcyc;
    logic [15:0] b;
    rst_n = 1'b0;
    cnt   = '0;
    repeat (3) @(negedge sclk);
    checks++; if (bcd !== 16'h0000) begin failures++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
    checks++; if (bcd_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", bcd_vld); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    observe(30, pos, pulses, bcyc, b);
    checks++; if (pos != 12) begin failures++; $display("FAIL first_conv_pos got=%0d exp=12", pos); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL first_conv_pulses got=%0d exp=1", pulses); end
    checks++; if (bcyc != 11) begin failures++; $display("FAIL first_conv_busy got=%0d exp=11", bcyc); end
    checks++; if (b !== 16'h0000) begin failures++; $display("FAIL first_conv_bcd got=%h exp=0000", b); end
  endtask

  task automatic test_max;
    int pos, pulses, bcyc;
    logic [15:0] b;
    cnt = 10'd1023;
    observe(40, pos, pulses, bcyc, b);
    checks++; if (b !== 16'h1023) begin failures++; $display("FAIL max_bcd got=%h exp=1023", b); end
    checks++; if (pos != 12) begin failures++; $display("FAIL max_pos got=%0d exp=12", pos); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL max_pulses got=%0d exp=1", pulses); end
    checks++; if (bcyc != 11) begin failures++; $display("FAIL max_busy got=%0d exp=11", bcyc); end
    checks++; if (bcd !== 16'h1023) begin failures++; $display("FAIL max_hold got=%h exp=1023", bcd); end
  endtask

  task automatic test_back_to_back;
    int p1 = 0;
    int p2 = 0;
    logic [15:0] b1 = '0;
    logic [15:0] b2 = '0;
    cnt = 10'd999;
    for (int k = 1; k <= 40; k++) begin
      @(negedge sclk);
      if (bcd_vld) begin
        if (p1 == 0) begin
          p1  = k;
          b1  = bcd;
          cnt = 10'd1000;
        end else if (p2 == 0) begin
          p2 = k;
          b2 = bcd;
        end
      end
    end
    checks++; if (p1 != 12) begin failures++; $display("FAIL b2b_first_pos got=%0d exp=12", p1); end
    checks++; if (b1 !== 16'h0999) begin failures++; $display("FAIL b2b_first_bcd got=%h exp=0999", b1); end
    checks++; if (p2 - p1 != 12) begin failures++; $display("FAIL b2b_spacing got=%0d exp=12", p2 - p1); end
    checks++; if (b2 !== 16'h1000) begin failures++; $display("FAIL b2b_second_bcd got=%h exp=1000", b2); end
  endtask

  task automatic test_drop;
    int pulses = 0;
    logic [15:0] seen [2];
    seen[0] = '0;
    seen[1] = '0;
    cnt = 10'd5;
    for (int k = 1; k <= 50; k++) begin
      @(negedge sclk);
      if (bcd_vld) begin
        if (pulses < 2) seen[pulses] = bcd;
        pulses++;
      end
      if (k == 2) cnt = 10'd6;
      if (k == 5) cnt = 10'd7;
    end
    checks++; if (pulses != 2) begin failures++; $display("FAIL drop_pulses got=%0d exp=2", pulses); end
    checks++; if (seen[0] !== 16'h0005) begin failures++; $display("FAIL drop_first got=%h exp=0005", seen[0]); end
    checks++; if (seen[1] !== 16'h0007) begin failures++; $display("FAIL drop_second got=%h exp=0007", seen[1]); end
  endtask

  task automatic test_reset_mid;
    int pos, pulses, bcyc;
    logic [15:0] b;
    cnt = 10'd512;
    repeat (4) @(negedge sclk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bcd !== 16'h0000) begin failures++; $display("FAIL mid_rst_bcd got=%h exp=0000", bcd); end
    checks++; if (bcd_vld !== 1'b0) begin failures++; $display("FAIL mid_rst_vld got=%b exp=0", bcd_vld); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    @(negedge sclk);
    rst_n = 1'b1;
    observe(30, pos, pulses, bcyc, b);
    checks++; if (b !== 16'h0512) begin failures++; $display("FAIL mid_post_bcd got=%h exp=0512", b); end
    checks++; if (pos != 12) begin failures++; $display("FAIL mid_post_pos got=%0d exp=12", pos); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL mid_post_pulses got=%0d exp=1", pulses); end
  endtask

  // Counter-stage model: advance only after each result so no value is dropped.
  task automatic test_sweep;
    bit got;
    int bad_digit;
    for (int v = 0; v < 1024; v++) begin
      cnt = 10'(v);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge sclk);
        if (bcd_vld) got = 1'b1;
      end
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL sweep_timeout value=%0d got=no_pulse exp=pulse", v);
      end else if (bcd !== ref_bcd(v)) begin
        failures++;
        $display("FAIL sweep_value value=%0d got=%h exp=%h", v, bcd, ref_bcd(v));
      end
      if (got) begin
        bad_digit = 0;
        for (int d = 0; d < 4; d++) if (bcd[4*d +: 4] > 4'd9) bad_digit++;
        checks++;
        if (bad_digit != 0) begin
          failures++;
          $display("FAIL sweep_digit value=%0d got=%h exp=digits_le_9", v, bcd);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cnt   = '0;
    test_reset;
    test_max;
    test_back_to_back;
    test_drop;
    test_reset_mid;
    test_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
